// File: rtl/dma_mem_responder.sv
// Word-addressed memory answering DMA transfers after a fixed latency, with a host
// backdoor port, sticky address-error flag and completed read/write counters.
module dma_mem_responder #(
  parameter logic [31:0] BASE_ADDR   = 32'h0000_0000,
  parameter int unsigned DEPTH_WORDS = 256,
  parameter int unsigned LATENCY     = 2
) (
  input  logic                           clk,
  input  logic                           reset,
  input  logic                           dma_req,
  input  logic                           dma_we,
  input  logic [31:0]                    dma_addr,
  input  logic [31:0]                    dma_data_i,
  output logic [31:0]                    dma_data_o,
  output logic                           dma_ack,
  input  logic                           host_we,
  input  logic [$clog2(DEPTH_WORDS)-1:0] host_addr,
  input  logic [31:0]                    host_wdata,
  output logic [31:0]                    host_rdata,
  output logic                           err,
  input  logic                           err_clr,
  output logic [15:0]                    rd_count,
  output logic [15:0]                    wr_count
);

  localparam int unsigned AW = $clog2(DEPTH_WORDS);
  localparam logic [3:0] LatM1 = 4'(LATENCY - 1);

  typedef enum logic [1:0] {StIdle, StWait, StAck} state_e;

  state_e        state_q, state_d;
  logic [3:0]    cnt_q, cnt_d;
  logic          we_q, we_d;
  logic [31:0]   wdata_q, wdata_d;
  logic [AW-1:0] idx_q, idx_d;
  logic          in_range_q, in_range_d;
  logic [31:0]   data_o_q, data_o_d;
  logic [31:0]   host_rdata_q, host_rdata_d;
  logic          err_q, err_d;
  logic [15:0]   rd_count_q, rd_count_d;
  logic [15:0]   wr_count_q, wr_count_d;

  logic [31:0]   mem_q [DEPTH_WORDS];

  logic [31:0]   off;
  logic [AW-1:0] dec_idx;
  logic          dec_in_range;
  logic          to_ack;
  logic          ack_we;
  logic          ack_in_range;
  logic [AW-1:0] ack_idx;
  logic          mem_we;

  // Both the offset and the raw address must be word aligned.
  always_comb begin
    off          = dma_addr - BASE_ADDR;
    dec_idx      = off[AW+1:2];
    dec_in_range = (dma_addr >= BASE_ADDR) && (off[31:AW+2] == '0) &&
                   (off[1:0] == 2'b00) && (dma_addr[1:0] == 2'b00);
  end

  always_comb begin
    state_d      = state_q;
    cnt_d        = cnt_q;
    we_d         = we_q;
    wdata_d      = wdata_q;
    idx_d        = idx_q;
    in_range_d   = in_range_q;
    data_o_d     = 32'h0;
    err_d        = err_clr ? 1'b0 : err_q;
    rd_count_d   = rd_count_q;
    wr_count_d   = wr_count_q;
    host_rdata_d = mem_q[host_addr];
    to_ack       = 1'b0;
    mem_we       = 1'b0;

    unique case (state_q)
      StIdle: begin
        if (dma_req) begin
          we_d       = dma_we;
          wdata_d    = dma_data_i;
          idx_d      = dec_idx;
          in_range_d = dec_in_range;
          cnt_d      = LatM1;
          if (LATENCY == 1) begin
            state_d = StAck;
            to_ack  = 1'b1;
          end else begin
            state_d = StWait;
          end
        end
      end
      StWait: begin
        if (!dma_req) begin
          state_d = StIdle;
        end else if (cnt_q <= 4'd1) begin
          state_d = StAck;
          to_ack  = 1'b1;
        end else begin
          cnt_d = cnt_q - 4'd1;
        end
      end
      StAck: begin
        state_d = StIdle;
        if (!in_range_q) begin
          err_d = 1'b1;
        end else if (we_q) begin
          mem_we     = 1'b1;
          wr_count_d = wr_count_q + 16'd1;
        end else begin
          rd_count_d = rd_count_q + 16'd1;
        end
      end
      default: state_d = StIdle;
    endcase

    // With single-cycle latency the ack is entered straight from idle, before the latch.
    ack_we       = (state_q == StIdle) ? dma_we : we_q;
    ack_in_range = (state_q == StIdle) ? dec_in_range : in_range_q;
    ack_idx      = (state_q == StIdle) ? dec_idx : idx_q;
    if (to_ack && !ack_we && ack_in_range) begin
      data_o_d = mem_q[ack_idx];
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q      <= StIdle;
      cnt_q        <= '0;
      we_q         <= 1'b0;
      wdata_q      <= '0;
      idx_q        <= '0;
      in_range_q   <= 1'b0;
      data_o_q     <= '0;
      host_rdata_q <= '0;
      err_q        <= 1'b0;
      rd_count_q   <= '0;
      wr_count_q   <= '0;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      we_q         <= we_d;
      wdata_q      <= wdata_d;
      idx_q        <= idx_d;
      in_range_q   <= in_range_d;
      data_o_q     <= data_o_d;
      host_rdata_q <= host_rdata_d;
      err_q        <= err_d;
      rd_count_q   <= rd_count_d;
      wr_count_q   <= wr_count_d;
    end
  end

  // Not reset; the DMA write is ordered last so it wins a same-word collision.
  always_ff @(posedge clk) begin
    if (host_we) begin
      mem_q[host_addr] <= host_wdata;
    end
    if (mem_we && !reset) begin
      mem_q[idx_q] <= wdata_q;
    end
  end

  assign dma_ack    = (state_q == StAck);
  assign dma_data_o = data_o_q;
  assign host_rdata = host_rdata_q;
  assign err        = err_q;
  assign rd_count   = rd_count_q;
  assign wr_count   = wr_count_q;

endmodule

// File: tb/tb_dma_mem_responder.sv
// Directed bench for dma_mem_responder with LATENCY=2, BASE_ADDR=0, DEPTH_WORDS=256.
module tb_dma_mem_responder;

  logic        clk = 1'b0;
  logic        reset;
  logic        dma_req;
  logic        dma_we;
  logic [31:0] dma_addr;
  logic [31:0] dma_data_i;
  logic [31:0] dma_data_o;
  logic        dma_ack;
  logic        host_we;
  logic [7:0]  host_addr;
  logic [31:0] host_wdata;
  logic [31:0] host_rdata;
  logic        err;
  logic        err_clr;
  logic [15:0] rd_count;
  logic [15:0] wr_count;

  int errors = 0;
  int checks = 0;

  dma_mem_responder #(
    .BASE_ADDR  (32'h0000_0000),
    .DEPTH_WORDS(256),
    .LATENCY    (2)
  ) dut (
    .clk       (clk),
    .reset     (reset),
    .dma_req   (dma_req),
    .dma_we    (dma_we),
    .dma_addr  (dma_addr),
    .dma_data_i(dma_data_i),
    .dma_data_o(dma_data_o),
    .dma_ack   (dma_ack),
    .host_we   (host_we),
    .host_addr (host_addr),
    .host_wdata(host_wdata),
    .host_rdata(host_rdata),
    .err       (err),
    .err_clr   (err_clr),
    .rd_count  (rd_count),
    .wr_count  (wr_count)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    reset      = 1'b1;
    dma_req    = 1'b0;
    dma_we     = 1'b0;
    dma_addr   = '0;
    dma_data_i = '0;
    host_we    = 1'b0;
    host_addr  = '0;
    host_wdata = '0;
    err_clr    = 1'b0;
    tick();
    tick();
    reset = 1'b0;
  endtask

  task automatic host_write(input logic [7:0] a, input logic [31:0] d);
    host_we    = 1'b1;
    host_addr  = a;
    host_wdata = d;
    tick();
    host_we = 1'b0;
  endtask

  task automatic host_read(input logic [7:0] a, output logic [31:0] d);
    host_addr = a;
    tick();
    d = host_rdata;
  endtask

  // Issues one transfer in cycle T; returns ack seen at T+1 and ack/data at T+2.
  task automatic dma_xfer(input logic we, input logic [31:0] a, input logic [31:0] wd,
                          output logic ack1, output logic ack2, output logic [31:0] rd);
    dma_req    = 1'b1;
    dma_we     = we;
    dma_addr   = a;
    dma_data_i = wd;
    tick();
    ack1 = dma_ack;
    tick();
    ack2    = dma_ack;
    rd      = dma_data_o;
    dma_req = 1'b0;
    tick();
  endtask

  task automatic test_reset();
    reset = 1'b1;
    tick();
    checks++;
    if (dma_ack !== 1'b0 || dma_data_o !== 32'h0 || err !== 1'b0 || rd_count !== 16'h0 ||
        wr_count !== 16'h0 || host_rdata !== 32'h0) begin
      errors++;
      $display("FAIL reset_state: ack=%b data=%h err=%b rd=%h wr=%h hr=%h, required all 0",
               dma_ack, dma_data_o, err, rd_count, wr_count, host_rdata);
    end
    reset = 1'b0;
  endtask

  task automatic test_read();
    logic a1, a2;
    logic [31:0] d;
    do_reset();
    host_write(8'd3, 32'hCAFE_0003);
    dma_xfer(1'b0, 32'h0000_000C, 32'h0, a1, a2, d);
    checks++;
    if (a1 !== 1'b0) begin
      errors++;
      $display("FAIL read_ack_t1: got %b required 0", a1);
    end
    checks++;
    if (a2 !== 1'b1 || d !== 32'hCAFE_0003) begin
      errors++;
      $display("FAIL read_ack_t2: ack=%b data=%h required 1 cafe0003", a2, d);
    end
    checks++;
    if (dma_ack !== 1'b0 || dma_data_o !== 32'h0) begin
      errors++;
      $display("FAIL read_after_ack: ack=%b data=%h required 0 0", dma_ack, dma_data_o);
    end
    checks++;
    if (rd_count !== 16'd1 || wr_count !== 16'd0) begin
      errors++;
      $display("FAIL read_count: rd=%0d wr=%0d required 1 0", rd_count, wr_count);
    end
  endtask

  task automatic test_back_to_back();
    logic [31:0] exp_d [3];
    int n;
    do_reset();
    exp_d[0] = 32'h1000_0000;
    exp_d[1] = 32'h1000_0001;
    exp_d[2] = 32'h1000_0002;
    for (int i = 0; i < 3; i++) host_write(8'(i), exp_d[i]);
    n        = 0;
    dma_req  = 1'b1;
    dma_we   = 1'b0;
    dma_addr = 32'h0;
    for (int c = 1; c <= 9; c++) begin
      tick();
      checks++;
      if (dma_ack !== ((c % 3) == 2)) begin
        errors++;
        $display("FAIL b2b_ack_cycle%0d: got %b required %b", c, dma_ack, (c % 3) == 2);
      end
      if (dma_ack === 1'b1 && n < 3) begin
        checks++;
        if (dma_data_o !== exp_d[n]) begin
          errors++;
          $display("FAIL b2b_data%0d: got %h required %h", n, dma_data_o, exp_d[n]);
        end
        n++;
        dma_addr = dma_addr + 32'd4;
        if (n == 3) dma_req = 1'b0;
      end
    end
    checks++;
    if (rd_count !== 16'd3) begin
      errors++;
      $display("FAIL b2b_count: got %0d required 3", rd_count);
    end
  endtask

  task automatic test_write();
    logic a1, a2;
    logic [31:0] d;
    do_reset();
    dma_xfer(1'b1, 32'h0000_0010, 32'h1234_5678, a1, a2, d);
    checks++;
    if (a2 !== 1'b1 || d !== 32'h0) begin
      errors++;
      $display("FAIL write_ack: ack=%b data=%h required 1 0", a2, d);
    end
    host_read(8'd4, d);
    checks++;
    if (d !== 32'h1234_5678) begin
      errors++;
      $display("FAIL write_mem: got %h required 12345678", d);
    end
    checks++;
    if (wr_count !== 16'd1 || rd_count !== 16'd0) begin
      errors++;
      $display("FAIL write_count: wr=%0d rd=%0d required 1 0", wr_count, rd_count);
    end
  endtask

  task automatic test_addr_error();
    logic a1, a2;
    logic [31:0] d;
    do_reset();
    host_write(8'd0, 32'h1111_0000);
    dma_xfer(1'b0, 32'h0000_0400, 32'h0, a1, a2, d);
    checks++;
    if (a2 !== 1'b1 || d !== 32'h0 || err !== 1'b1) begin
      errors++;
      $display("FAIL oor_read: ack=%b data=%h err=%b required 1 0 1", a2, d, err);
    end
    err_clr = 1'b1;
    tick();
    err_clr = 1'b0;
    checks++;
    if (err !== 1'b0) begin
      errors++;
      $display("FAIL err_clr: got %b required 0", err);
    end
    dma_xfer(1'b1, 32'h0000_0002, 32'hDEAD_BEEF, a1, a2, d);
    checks++;
    if (a2 !== 1'b1 || err !== 1'b1) begin
      errors++;
      $display("FAIL misaligned_write: ack=%b err=%b required 1 1", a2, err);
    end
    host_read(8'd0, d);
    checks++;
    if (d !== 32'h1111_0000 || rd_count !== 16'd0 || wr_count !== 16'd0) begin
      errors++;
      $display("FAIL err_side_effects: mem0=%h rd=%0d wr=%0d required 11110000 0 0",
               d, rd_count, wr_count);
    end
    // Clear held through a fresh error: set must win.
    err_clr = 1'b1;
    tick();
    dma_req  = 1'b1;
    dma_we   = 1'b0;
    dma_addr = 32'h0000_0401;
    tick();
    tick();
    dma_req = 1'b0;
    tick();
    err_clr = 1'b0;
    checks++;
    if (err !== 1'b1) begin
      errors++;
      $display("FAIL err_set_wins: got %b required 1", err);
    end
  endtask

  task automatic test_abort();
    logic [31:0] d;
    logic seen;
    do_reset();
    host_write(8'd6, 32'h6666_6666);
    // Request dropped in WAIT.
    dma_req    = 1'b1;
    dma_we     = 1'b1;
    dma_addr   = 32'h0000_0018;
    dma_data_i = 32'h0000_0BAD;
    tick();
    dma_req = 1'b0;
    seen    = 1'b0;
    for (int c = 0; c < 4; c++) begin
      tick();
      seen |= dma_ack;
    end
    checks++;
    if (seen !== 1'b0) begin
      errors++;
      $display("FAIL abort_ack: got %b required 0", seen);
    end
    // Reset in WAIT.
    dma_req = 1'b1;
    tick();
    reset = 1'b1;
    tick();
    reset   = 1'b0;
    dma_req = 1'b0;
    seen    = 1'b0;
    for (int c = 0; c < 4; c++) begin
      tick();
      seen |= dma_ack;
    end
    checks++;
    if (seen !== 1'b0) begin
      errors++;
      $display("FAIL reset_abort_ack: got %b required 0", seen);
    end
    host_read(8'd6, d);
    checks++;
    if (d !== 32'h6666_6666 || rd_count !== 16'd0 || wr_count !== 16'd0) begin
      errors++;
      $display("FAIL abort_effects: mem6=%h rd=%0d wr=%0d required 66666666 0 0",
               d, rd_count, wr_count);
    end
  endtask

  task automatic test_collision();
    logic [31:0] d;
    do_reset();
    for (int k = 0; k < 2; k++) begin
      dma_req    = 1'b1;
      dma_we     = 1'b1;
      dma_addr   = (k == 0) ? 32'h0000_0014 : 32'h0000_0020;
      dma_data_i = 32'h0000_BBBB;
      tick();
      tick();
      // Ack cycle: host writes in the same edge as the DMA write.
      dma_req    = 1'b0;
      host_we    = 1'b1;
      host_addr  = (k == 0) ? 8'd5 : 8'd7;
      host_wdata = 32'h0000_AAAA;
      tick();
      host_we = 1'b0;
    end
    host_read(8'd5, d);
    checks++;
    if (d !== 32'h0000_BBBB) begin
      errors++;
      $display("FAIL collision_same: mem5=%h required 0000bbbb", d);
    end
    host_read(8'd7, d);
    checks++;
    if (d !== 32'h0000_AAAA) begin
      errors++;
      $display("FAIL collision_host: mem7=%h required 0000aaaa", d);
    end
    host_read(8'd8, d);
    checks++;
    if (d !== 32'h0000_BBBB || wr_count !== 16'd2) begin
      errors++;
      $display("FAIL collision_dma: mem8=%h wr=%0d required 0000bbbb 2", d, wr_count);
    end
  endtask

  task automatic test_host_rbw();
    logic [31:0] d;
    host_write(8'd9, 32'h0000_0009);
    host_we    = 1'b1;
    host_addr  = 8'd9;
    host_wdata = 32'h9999_9999;
    tick();
    host_we = 1'b0;
    d       = host_rdata;
    checks++;
    if (d !== 32'h0000_0009) begin
      errors++;
      $display("FAIL host_rbw_old: got %h required 00000009", d);
    end
    tick();
    checks++;
    if (host_rdata !== 32'h9999_9999) begin
      errors++;
      $display("FAIL host_rbw_new: got %h required 99999999", host_rdata);
    end
  endtask

  task automatic test_mem_survives_reset();
    logic [31:0] d;
    do_reset();
    host_read(8'd3, d);
    checks++;
    if (d !== 32'hCAFE_0003) begin
      errors++;
      $display("FAIL mem_after_reset: got %h required cafe0003", d);
    end
  endtask

  initial begin
    do_reset();
    test_reset();
    test_read();
    test_back_to_back();
    test_write();
    test_addr_error();
    test_abort();
    test_collision();
    test_host_rbw();
    test_mem_survives_reset();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not finish, required finish before 200000");
    $fatal(1);
  end

endmodule
